i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: CLCK cycles per SCL quarter-period; legal range 2..1023.
REQ-002 SHALL have port CLCK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  request one transaction; sampled only in IDLE.
REQ-005 SHALL have port RW  input  1  transfer direction: 0 write, 1 read; captured with START.
REQ-006 SHALL have port ADDR  input  7  slave address; captured with START.
REQ-007 SHALL have port WDATA  input  8  write byte; captured with START.
REQ-008 SHALL have port RDATA  output  8  read byte; valid when DONE=1 and RW was 1.
REQ-009 SHALL have port BUSY  output  1  high from START acceptance until DONE.
REQ-010 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ACK_ERR  output  1  NACK seen; valid with DONE, held until next START.
REQ-012 SHALL have port SCL  output  1  I2C clock, push-pull; idle high.
REQ-013 SHALL have port SDA  inout  1  I2C data, open-drain: drives 0 or high-Z, never 1.

Function
REQ-014 SHALL use a quarter counter of CLK_DIV cycles; each bit slot is 4 quarters: Q0/Q1 SCL=0, Q2/Q3 SCL=1.
REQ-015 SHALL change SDA only at Q0 entry; SHALL sample SDA in the last cycle of Q2.
REQ-016 SHALL implement states IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP, FIN.
REQ-017 IDLE: SCL=1, SDA released; START=1 captures RW/ADDR/WDATA, sets BUSY, clears ACK_ERR, goes to START.
REQ-018 START state: 4 quarters; SDA released Q0-Q1, pulled low Q2-Q3 with SCL high; SCL then low entering ADDR.
REQ-019 ADDR: 8 slots, shifting {ADDR,RW} MSB first.
REQ-020 ACK_A: SDA released; sampled 1 sets ACK_ERR and goes to STOP; sampled 0 goes to DATA.
REQ-021 DATA, write: 8 slots driving WDATA MSB first; ACK_D releases SDA; sampled 1 sets ACK_ERR.
REQ-022 DATA, read: SDA released; 8 sampled bits shift into RDATA MSB first; ACK_D drives 1 (released, NACK), ending the single-byte read.
REQ-023 STOP: 4 quarters; SDA low Q0-Q2 with SCL low Q0-Q1 and high Q2; SDA released in Q3 with SCL high.
REQ-024 FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE; START in the FIN cycle is ignored.
REQ-025 Full transaction SHALL take 80*CLK_DIV cycles from the cycle after START acceptance to the DONE cycle; an address NACK SHALL take 44*CLK_DIV.
REQ-026 START while BUSY=1 SHALL be ignored, with no effect on captured data.
REQ-027 RDATA SHALL hold its last value except while shifting during a read.
REQ-028 SHALL not support clock stretching, arbitration or repeated start; SCL is never sampled.

Reset
REQ-029 RST_N=0 SHALL immediately force IDLE with SCL=1, SDA high-Z, BUSY=0, DONE=0, ACK_ERR=0, RDATA=0x00, counters 0.
REQ-030 Reset mid-transaction SHALL abort with no STOP generated; the next START after release SHALL run a complete, normal transaction.

Verification
REQ-031 Write with ACK: CLK_DIV=4, ADDR=0x62, RW=0, WDATA=0xA5, slave model ACKs -> SDA bytes 0xC4 then 0xA5; DONE at cycle 320; ACK_ERR=0.
REQ-032 Read: ADDR=0x62, RW=1, slave drives 0x3C -> address byte 0xC5; RDATA=0x3C at DONE; master releases SDA on the 9th data clock.
REQ-033 Address NACK: no slave present, pull-up only -> ACK_ERR=1; STOP follows the 9th clock; DONE at cycle 176; no data clocks.
REQ-034 Protocol check: monitor flags any SDA change while SCL=1 other than the START fall and STOP rise; zero violations across all scenarios.
REQ-035 Reset mid-DATA, asserted in write bit 3 -> SCL=1, SDA=Z, BUSY=0 the same cycle; a following write of 0x5A completes with ACK_ERR=0.
REQ-036 START held high through a busy transaction and the FIN cycle -> exactly one transaction runs, and a second one is accepted only in the cycle after FIN.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// SCL is push-pull, SDA is open-drain; each bit slot is four CLK_DIV-cycle quarters.
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLCK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       RW,
  input  logic [6:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAckA, StData, StAckD, StStop, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              ack_err_q, ack_err_d;

  logic qtr_end, slot_end, smp_now, sda_in, sda_pull, scl_int;

  assign sda_in   = SDA;
  assign qtr_end  = (cnt_q == CntW'(CLK_DIV - 1));
  assign slot_end = qtr_end && (qtr_q == 2'd3);
  // Sample in the last cycle of Q2, the middle of the SCL high phase.
  assign smp_now  = qtr_end && (qtr_q == 2'd2);

  always_ff @(posedge CLCK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      rdata_q   <= 8'h00;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    qtr_d     = 2'd0;
    bit_d     = bit_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;

    if (state_q != StIdle && state_q != StFin) begin
      cnt_d = qtr_end ? '0 : cnt_q + CntW'(1);
      qtr_d = qtr_end ? qtr_q + 2'd1 : qtr_q;
    end

    unique case (state_q)
      StIdle: begin
        if (START) begin
          rw_d      = RW;
          wdata_d   = WDATA;
          shift_d   = {ADDR, RW};
          bit_d     = 3'd0;
          ack_err_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: if (slot_end) state_d = StAddr;
      StAddr: begin
        if (slot_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StAckA;
        end
      end
      StAckA: begin
        if (smp_now && sda_in) ack_err_d = 1'b1;
        if (slot_end) begin
          shift_d = wdata_q;
          state_d = ack_err_q ? StStop : StData;
        end
      end
      StData: begin
        if (smp_now && rw_q) rdata_d = {rdata_q[6:0], sda_in};
        if (slot_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StAckD;
        end
      end
      StAckD: begin
        // On a read the master itself NACKs, so only a write can flag an error here.
        if (smp_now && !rw_q && sda_in) ack_err_d = 1'b1;
        if (slot_end) state_d = StStop;
      end
      StStop: if (slot_end) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scl_int  = 1'b1;
    sda_pull = 1'b0;
    unique case (state_q)
      StStart: sda_pull = qtr_q[1];
      StAddr: begin
        scl_int  = qtr_q[1];
        sda_pull = ~shift_q[7];
      end
      StAckA, StAckD: scl_int = qtr_q[1];
      StData: begin
        scl_int  = qtr_q[1];
        sda_pull = ~rw_q & ~shift_q[7];
      end
      StStop: begin
        scl_int  = qtr_q[1];
        sda_pull = (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign SCL     = scl_int;
  assign SDA     = sda_pull ? 1'b0 : 1'bz;
  assign RDATA   = rdata_q;
  assign ACK_ERR = ack_err_q;
  assign BUSY    = (state_q != StIdle) && (state_q != StFin);
  assign DONE    = (state_q == StFin);

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural slave and an SDA/SCL protocol monitor.
`timescale 1ns/1ps
module tb_i2c_master;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, ack_err, scl;
  wire        sda;

  logic       slv_oe = 1'b0;
  logic       slv_present = 1'b1;
  logic [7:0] slv_rd = 8'h00;
  assign sda = slv_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master #(.CLK_DIV(4)) dut (
    .CLCK(clk), .RST_N(rst_n), .START(start), .RW(rw), .ADDR(addr), .WDATA(wdata),
    .RDATA(rdata), .BUSY(busy), .DONE(done), .ACK_ERR(ack_err), .SCL(scl), .SDA(sda)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: records every bit clocked on SCL rise, drives ACK / read data after SCL falls.
  int         slv_bits = 0;
  int         scl_rises = 0;
  logic [7:0] slv_addr = 8'h00, slv_data = 8'h00;
  logic       slv_ack1 = 1'b0, slv_ack2 = 1'b0;

  always @(posedge scl) begin
    scl_rises++;
    if (slv_bits < 8)       slv_addr = {slv_addr[6:0], sda};
    else if (slv_bits == 8) slv_ack1 = sda;
    else if (slv_bits < 17) slv_data = {slv_data[6:0], sda};
    else if (slv_bits == 17) slv_ack2 = sda;
    slv_bits++;
  end

  always @(negedge scl) begin
    if (slv_bits == 8)
      slv_oe = slv_present;
    else if (slv_bits >= 9 && slv_bits <= 16 && slv_present && slv_addr[0])
      slv_oe = ~slv_rd[16 - slv_bits];
    else if (slv_bits == 17)
      slv_oe = slv_present && !slv_addr[0];
    else
      slv_oe = 1'b0;
  end

  // Monitor: SDA edges while SCL stays high; a fall is a START, a rise is a STOP.
  logic mon_scl = 1'b1, mon_sda = 1'b1;
  int   start_ev = 0, stop_ev = 0;
  always @(posedge clk) begin
    #1;
    if (mon_scl && scl && sda != mon_sda) begin
      if (!sda) start_ev++;
      else      stop_ev++;
    end
    mon_scl = scl;
    mon_sda = sda;
  end

  task automatic clear_obs();
    slv_bits = 0; scl_rises = 0; start_ev = 0; stop_ev = 0;
    slv_addr = 8'h00; slv_data = 8'h00;
  endtask

  // Returns at the negedge right after the accepting clock edge.
  task automatic begin_txn(input logic r, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    clear_obs();
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_scl", scl, 1'b1);
    check_eq("rst_sda", sda, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ackerr", ack_err, 1'b0);
    check_eq("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write with ACK
    slv_present = 1'b1;
    begin_txn(1'b0, 7'h62, 8'hA5);
    check_eq("wr_busy_acc", busy, 1'b1);
    wait_done(cyc);
    check_eq("wr_cycles", cyc, 320);
    check_eq("wr_busy_fin", busy, 1'b0);
    check_eq("wr_ackerr", ack_err, 1'b0);
    check_eq("wr_addr_byte", slv_addr, 8'hC4);
    check_eq("wr_data_byte", slv_data, 8'hA5);
    check_eq("wr_ack1", slv_ack1, 1'b0);
    check_eq("wr_ack2", slv_ack2, 1'b0);
    check_eq("wr_scl_rises", scl_rises, 19);
    check_eq("wr_start_ev", start_ev, 1);
    check_eq("wr_stop_ev", stop_ev, 1);
    @(negedge clk);
    check_eq("wr_done_pulse", done, 1'b0);

    // Read, slave returns 0x3C
    slv_rd = 8'h3C;
    begin_txn(1'b1, 7'h62, 8'h00);
    wait_done(cyc);
    check_eq("rd_cycles", cyc, 320);
    check_eq("rd_addr_byte", slv_addr, 8'hC5);
    check_eq("rd_rdata", rdata, 8'h3C);
    check_eq("rd_bus_byte", slv_data, 8'h3C);
    check_eq("rd_master_nack", slv_ack2, 1'b1);
    check_eq("rd_ackerr", ack_err, 1'b0);
    check_eq("rd_start_ev", start_ev, 1);
    check_eq("rd_stop_ev", stop_ev, 1);

    // Address NACK, pull-up only
    slv_present = 1'b0;
    begin_txn(1'b0, 7'h62, 8'hA5);
    wait_done(cyc);
    check_eq("nack_cycles", cyc, 176);
    check_eq("nack_ackerr", ack_err, 1'b1);
    check_eq("nack_addr_byte", slv_addr, 8'hC4);
    check_eq("nack_ack1", slv_ack1, 1'b1);
    check_eq("nack_scl_rises", scl_rises, 10);
    check_eq("nack_stop_ev", stop_ev, 1);
    check_eq("nack_rdata_hold", rdata, 8'h3C);
    repeat (5) @(negedge clk);
    check_eq("nack_ackerr_held", ack_err, 1'b1);

    // Reset in write data bit 3 (Q1 of that slot, SCL low, SDA pulled for a 0)
    slv_present = 1'b1;
    begin_txn(1'b0, 7'h62, 8'hA5);
    repeat (229) @(negedge clk);
    check_eq("abort_pre_scl", scl, 1'b0);
    check_eq("abort_pre_sda", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_scl", scl, 1'b1);
    check_eq("abort_sda", sda, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_txn(1'b0, 7'h62, 8'h5A);
    wait_done(cyc);
    check_eq("post_cycles", cyc, 320);
    check_eq("post_data_byte", slv_data, 8'h5A);
    check_eq("post_ackerr", ack_err, 1'b0);
    check_eq("post_start_ev", start_ev, 1);
    check_eq("post_stop_ev", stop_ev, 1);

    // START held high across a whole transaction and its FIN cycle
    @(negedge clk);
    clear_obs();
    rw = 1'b0; addr = 7'h62; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    check_eq("hold_busy_acc", busy, 1'b1);
    addr = 7'h11; wdata = 8'h00;
    wait_done(cyc);
    check_eq("hold_cycles", cyc, 320);
    check_eq("hold_addr_byte", slv_addr, 8'hC4);
    check_eq("hold_data_byte", slv_data, 8'hA5);
    check_eq("hold_start_ev", start_ev, 1);
    @(negedge clk);
    check_eq("hold_idle_busy", busy, 1'b0);
    clear_obs();
    @(negedge clk);
    check_eq("hold_reaccept", busy, 1'b1);
    start = 1'b0;
    wait_done(cyc);
    check_eq("hold2_cycles", cyc, 320);
    check_eq("hold2_addr_byte", slv_addr, 8'h22);
    check_eq("hold2_data_byte", slv_data, 8'h00);
    check_eq("hold2_stop_ev", stop_ev, 1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
